conv_scheduler: RTL and testbench

- Sequences the shared MAC datapath of the convolution engine.
- Walks every output window position (row, col) of the input picture and, at each position, every one of CONV_NUM filters.
- For each window/filter pair it issues one MAC operation, waits for mac_done, then writes the result to a linear result address.
- Sits between the top-level control FSM (start/done) and the datapath (window load, filter select, MAC, result memory).

---
 rtl/conv_scheduler_if.sv | 34 +++
 rtl/conv_scheduler.sv | 156 +++++++++++++++
 tb/tb_conv_scheduler.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/conv_scheduler_if.sv
// Handshake bundle between the convolution control FSM, the scheduler and
// the shared MAC datapath. The master side is the control/datapath
// environment; the slave side is the scheduler itself.
interface conv_scheduler_if #(
  parameter int CONV_NUM = 2,
  parameter int ADDR_W   = 16
);
  logic                start;
  logic                abort;
  logic [7:0]          img_rows;
  logic [7:0]          img_cols;
  logic                mac_done;
  logic [7:0]          win_row;
  logic [7:0]          win_col;
  logic                ld_win;
  logic [CONV_NUM-1:0] filt_sel;
  logic                mac_start;
  logic                res_we;
  logic [ADDR_W-1:0]   res_addr;
  logic                busy;
  logic                done;

  modport master (
    output start, abort, img_rows, img_cols, mac_done,
    input  win_row, win_col, ld_win, filt_sel, mac_start, res_we, res_addr,
           busy, done
  );

  modport slave (
    input  start, abort, img_rows, img_cols, mac_done,
    output win_row, win_col, ld_win, filt_sel, mac_start, res_we, res_addr,
           busy, done
  );
endinterface

// File: rtl/conv_scheduler.sv
// Convolution scheduler: walks every output window row-major and, inside each
// window, every filter; issues one MAC per window/filter pair, waits for its
// completion and writes the result to a linearly incrementing address.
module conv_scheduler #(
  parameter int CONV_NUM = 2,
  parameter int K        = 3,
  parameter int ADDR_W   = 16
) (
  input logic             clk,
  input logic             rst,
  conv_scheduler_if.slave bus
);

  localparam int              FW     = (CONV_NUM > 1) ? $clog2(CONV_NUM) : 1;
  localparam logic [FW-1:0]   LAST_F = FW'(CONV_NUM - 1);
  localparam logic [7:0]      K8     = 8'(K);
  localparam logic [8:0]      K9     = 9'(K);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_WRITE,
    S_ADVANCE,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [7:0]          r_rows;
  logic [7:0]          r_cols;
  logic [7:0]          r_win_row;
  logic [7:0]          r_win_col;
  logic [FW-1:0]       r_filt_idx;
  logic [CONV_NUM-1:0] r_filt_sel;
  logic [ADDR_W-1:0]   r_res_addr;
  logic                r_ld_win;
  logic                r_mac_start;
  logic                r_res_we;
  logic                r_done;

  logic [8:0]          w_out_rows;
  logic [8:0]          w_out_cols;

  // Output window counts from the latched picture size; 9 bits keeps the
  // intermediate subtraction from wrapping.
  assign w_out_rows = {1'b0, r_rows} - K9 + 9'd1;
  assign w_out_cols = {1'b0, r_cols} - K9 + 9'd1;

  // Sequencer: state, position counters and registered one-cycle strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_rows      <= '0;
      r_cols      <= '0;
      r_win_row   <= '0;
      r_win_col   <= '0;
      r_filt_idx  <= '0;
      r_filt_sel  <= CONV_NUM'(1);
      r_res_addr  <= '0;
      r_ld_win    <= 1'b0;
      r_mac_start <= 1'b0;
      r_res_we    <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_ld_win    <= 1'b0;
      r_mac_start <= 1'b0;
      r_res_we    <= 1'b0;
      r_done      <= 1'b0;
      if (r_state != S_IDLE && bus.abort) begin
        // Cancel: strobes already cleared above, counters left untouched.
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.start) begin
              r_rows     <= bus.img_rows;
              r_cols     <= bus.img_cols;
              r_win_row  <= '0;
              r_win_col  <= '0;
              r_filt_idx <= '0;
              r_filt_sel <= CONV_NUM'(1);
              r_res_addr <= '0;
              if (bus.img_rows < K8 || bus.img_cols < K8) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state  <= S_LOAD;
                r_ld_win <= 1'b1;
              end
            end
          end
          S_LOAD: begin
            r_state     <= S_ISSUE;
            r_mac_start <= 1'b1;
          end
          S_ISSUE: begin
            r_state <= S_WAIT;
          end
          S_WAIT: begin
            if (bus.mac_done) begin
              r_state  <= S_WRITE;
              r_res_we <= 1'b1;
            end
          end
          S_WRITE: begin
            r_res_addr <= r_res_addr + ADDR_W'(1);
            if (r_filt_idx < LAST_F) begin
              // Next filter reuses the window already loaded.
              r_filt_idx  <= r_filt_idx + FW'(1);
              r_filt_sel  <= (r_filt_sel << 1) | (r_filt_sel >> (CONV_NUM - 1));
              r_state     <= S_ISSUE;
              r_mac_start <= 1'b1;
            end else begin
              r_state <= S_ADVANCE;
            end
          end
          S_ADVANCE: begin
            r_filt_idx <= '0;
            r_filt_sel <= CONV_NUM'(1);
            if ({1'b0, r_win_col} < (w_out_cols - 9'd1)) begin
              r_win_col <= r_win_col + 8'd1;
              r_state   <= S_LOAD;
              r_ld_win  <= 1'b1;
            end else if ({1'b0, r_win_row} < (w_out_rows - 9'd1)) begin
              r_win_col <= '0;
              r_win_row <= r_win_row + 8'd1;
              r_state   <= S_LOAD;
              r_ld_win  <= 1'b1;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.win_row   = r_win_row;
  assign bus.win_col   = r_win_col;
  assign bus.ld_win    = r_ld_win;
  assign bus.filt_sel  = r_filt_sel;
  assign bus.mac_start = r_mac_start;
  assign bus.res_we    = r_res_we;
  assign bus.res_addr  = r_res_addr;
  assign bus.done      = r_done;
  assign bus.busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_conv_scheduler.sv
// Randomised self-checking bench for conv_scheduler. Expected window order,
// result addresses, filter selects and run length come from a reference
// model built with nested loops over the output picture.
module tb_conv_scheduler;

  localparam int K  = 3;
  localparam int CN = 2;
  localparam int AW = 16;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  conv_scheduler_if #(.CONV_NUM(CN), .ADDR_W(AW)) bus ();

  conv_scheduler #(.CONV_NUM(CN), .K(K), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},  32'(bus.busy), 0);
    chk({tag, "_done"},  32'(bus.done), 0);
    chk({tag, "_ld"},    32'(bus.ld_win), 0);
    chk({tag, "_ms"},    32'(bus.mac_start), 0);
    chk({tag, "_we"},    32'(bus.res_we), 0);
    chk({tag, "_row"},   32'(bus.win_row), 0);
    chk({tag, "_col"},   32'(bus.win_col), 0);
    chk({tag, "_addr"},  32'(bus.res_addr), 0);
    chk({tag, "_sel"},   32'(bus.filt_sel), 1);
  endtask

  // One scheduler run: drives start, answers mac_start with mac_done after
  // lat cycles, and compares every strobe against the reference model.
  //   spur: extra mac_done in ISSUE;  hold: leave start high afterwards
  //   pre: idle cycles before the run begins;  abort_issue / rst_issue: cut
  //   the run in the first WAIT cycle after that MAC issue;  poke: pulse
  //   start with junk sizes mid-run.
  task automatic run(input int rows, input int cols, input int lat,
                     input bit spur, input bit hold, input int pre,
                     input int abort_issue, input int rst_issue, input bit poke);
    int orows, ocols, nwin, exp_cycles;
    int n, busy_n, issues, writes, cd, last_ms, done_at, e;
    bit fin, cut;
    int exp_ld[$];
    int exp_addr[$];
    int exp_sel[$];
    int exp_rc[$];

    nwin = 0;
    if (rows >= K && cols >= K) begin
      orows = rows - K + 1;
      ocols = cols - K + 1;
      nwin  = orows * ocols;
      for (int r = 0; r < orows; r++)
        for (int c = 0; c < ocols; c++) begin
          exp_ld.push_back(r * 256 + c);
          for (int f = 0; f < CN; f++) begin
            exp_addr.push_back(((r * ocols + c) * CN + f) % (1 << AW));
            exp_sel.push_back(1 << f);
            exp_rc.push_back(r * 256 + c);
          end
        end
    end
    exp_cycles = nwin * (2 + CN * (2 + lat)) + 1;

    bus.start    = 1'b1;
    bus.img_rows = 8'(rows);
    bus.img_cols = 8'(cols);
    n = 0; busy_n = 0; issues = 0; writes = 0; cd = 0; last_ms = 0;
    done_at = 0; fin = 1'b0; cut = 1'b0;

    while (!fin) begin
      @(negedge clk);
      n++;
      if (!hold && n > pre) bus.start = (poke && n == 10);
      if (!hold && n == pre + 1) begin
        bus.img_rows = 8'($urandom_range(0, 255));
        bus.img_cols = 8'($urandom_range(0, 255));
      end

      if (bus.busy) busy_n++;
      if (bus.ld_win) begin
        if (exp_ld.size() == 0) chk("ld_extra", 1, 0);
        else begin
          e = exp_ld.pop_front();
          chk("ld_pos", {16'd0, bus.win_row, bus.win_col}, 32'(e));
        end
      end
      if (bus.res_we) begin
        writes++;
        chk("wait_len", 32'(n - last_ms - 1), 32'(lat));
        if (exp_addr.size() == 0) chk("we_extra", 1, 0);
        else begin
          chk("we_addr", 32'(bus.res_addr), 32'(exp_addr.pop_front()));
          chk("we_sel",  32'(bus.filt_sel), 32'(exp_sel.pop_front()));
          chk("we_pos",  {16'd0, bus.win_row, bus.win_col}, 32'(exp_rc.pop_front()));
        end
      end

      bus.mac_done = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) bus.mac_done = 1'b1;
      end
      if (bus.mac_start) begin
        issues++;
        last_ms = n;
        cd = lat;
        if (spur) bus.mac_done = 1'b1;
      end

      if (abort_issue != 0 && issues == abort_issue && n == last_ms + 1) begin
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        bus.mac_done = 1'b0;
        cd = 0;
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_we",   32'(bus.res_we), 0);
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          chk("abort_nodone", 32'(bus.done), 0);
        end
        fin = 1'b1;
        cut = 1'b1;
      end else if (rst_issue != 0 && issues == rst_issue && n == last_ms + 1) begin
        #2 rst = 1'b0;
        #1;
        chk_reset_outputs("rst_mid");
        @(negedge clk);
        bus.mac_done = 1'b0;
        cd = 0;
        chk_reset_outputs("rst_hold");
        rst = 1'b1;
        fin = 1'b1;
        cut = 1'b1;
      end else if (bus.done) begin
        done_at = n;
        fin = 1'b1;
      end else if (n > 5000) begin
        chk("timeout", 32'(n), 32'(exp_cycles + pre));
        fin = 1'b1;
        cut = 1'b1;
      end
    end

    bus.mac_done = 1'b0;
    if (!hold) bus.start = 1'b0;
    if (!cut) begin
      chk("done_cycle", 32'(done_at), 32'(exp_cycles + pre));
      chk("busy_count", 32'(busy_n), 32'(exp_cycles));
      chk("issues",     32'(issues), 32'(nwin * CN));
      chk("writes",     32'(writes), 32'(nwin * CN));
      chk("ld_left",    32'(exp_ld.size()), 0);
      if (!hold) begin
        @(negedge clk);
        chk("post_done", 32'(bus.done), 0);
        chk("post_busy", 32'(bus.busy), 0);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst          = 1'b0;
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    bus.mac_done = 1'b0;
    bus.img_rows = 8'd0;
    bus.img_cols = 8'd0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst_init");
    rst = 1'b1;
    @(negedge clk);

    // Basic 4x4 run, single-cycle MAC.
    run(4, 4, 1, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    // Slow MAC with a spurious mac_done in ISSUE.
    run(4, 4, 5, 1'b1, 1'b0, 0, 0, 0, 1'b0);
    // Picture smaller than the filter.
    run(2, 4, 1, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    run(5, 2, 3, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    // Exactly one window.
    run(3, 3, 2, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    // Abort during the third WAIT, then a clean rerun from address 0.
    run(4, 4, 5, 1'b0, 1'b0, 0, 3, 0, 1'b0);
    run(4, 4, 1, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    // Asynchronous reset during the fourth WAIT, then a clean rerun.
    run(4, 4, 5, 1'b0, 1'b0, 0, 0, 4, 1'b0);
    run(4, 4, 2, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    // start held across DONE: second run follows after one IDLE cycle.
    run(4, 4, 1, 1'b0, 1'b1, 0, 0, 0, 1'b0);
    run(4, 4, 1, 1'b0, 1'b0, 1, 0, 0, 1'b0);
    // start pulsed with junk sizes while busy.
    run(4, 4, 1, 1'b0, 1'b0, 0, 0, 0, 1'b1);
    // Randomised picture sizes and MAC latencies.
    for (int t = 0; t < 8; t++) begin
      run(int'($urandom_range(1, 7)), int'($urandom_range(1, 7)),
          int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)),
          1'b0, 0, 0, 0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
